// File: rtl/axi2sram_pkg.sv
// Shared types and constants for the AXI4-Lite to byte-wide SRAM bridge.
// Used by axi2sram_byte_bridge; the optional AXI2SRAM_RANGE_CHECK_EN build
// reuses RESP_SLVERR from here.
package axi2sram_pkg;

  localparam int LANES           = 4;
  localparam int SRAM_AW_DEFAULT = 13;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BYTE = 3'd1,
    WR_RESP = 3'd2,
    RD_BYTE = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  // Lowest set lane in a strobe mask (0 when the mask is empty).
  function automatic logic [1:0] first_lane(input logic [LANES-1:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) r = i[1:0];
    end
    return r;
  endfunction

  // One-hot mask for a lane index.
  function automatic logic [LANES-1:0] lane_bit(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/axi2sram_byte_bridge_if.sv
// AXI4-Lite channel bundle between an AXI master and axi2sram_byte_bridge.
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where both valid and ready are high; valid, once raised, is held with its
// payload stable until that edge; ready may depend combinationally on valid.
interface axi2sram_byte_bridge_if #(
  parameter int AXI_AW = 32
);

  logic              awvalid;
  logic              awready;
  logic [AXI_AW-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [AXI_AW-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi2sram_byte_bridge.sv
// AXI4-Lite slave that turns 32-bit word accesses into one byte access per
// clock on a single-port 8-bit SRAM. Writes touch only strobed lanes (lowest
// first); reads always fetch lanes 0..3. One transaction outstanding.
// Build option: AXI2SRAM_RANGE_CHECK_EN answers addresses above the SRAM with
// SLVERR and no SRAM cycle; without it upper address bits alias.
module axi2sram_byte_bridge
  import axi2sram_pkg::*;
#(
  parameter int AXI_AW  = 32,
  parameter int SRAM_AW = SRAM_AW_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  axi2sram_byte_bridge_if.slave axi,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [SRAM_AW-1:0]    sram_addr0,
  output logic [7:0]            sram_din0,
  input  logic [7:0]            sram_dout0,
  output state_e                dbg_state
);

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [LANES-1:0]   strb_q, strb_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               last_wr_q, last_wr_d;
  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [SRAM_AW-1:0] addr0_q, addr0_d;
  logic [7:0]         din0_q, din0_d;

  logic               wr_elig, rd_elig;
  logic               grant_wr, grant_rd;
  logic               wr_oor, rd_oor;
  logic [1:0]         first_wr, next_wr;
  logic               unused_addr_bits;

  // Request eligibility, out-of-range detection and round-robin grant in IDLE.
  always_comb begin
    wr_elig = axi.awvalid && axi.wvalid && !reset;
    rd_elig = axi.arvalid && !reset;
`ifdef AXI2SRAM_RANGE_CHECK_EN
    wr_oor  = |axi.awaddr[AXI_AW-1:SRAM_AW];
    rd_oor  = |axi.araddr[AXI_AW-1:SRAM_AW];
`else
    wr_oor  = 1'b0;
    rd_oor  = 1'b0;
`endif
    // last_wr set means the write won last time, so the read goes first.
    grant_rd = (state_q == IDLE) && rd_elig && (!wr_elig || last_wr_q);
    grant_wr = (state_q == IDLE) && wr_elig && !grant_rd;
  end

  // Byte-offset and (without range checking) upper address bits carry no meaning.
  assign unused_addr_bits = ^{axi.awaddr[1:0], axi.araddr[1:0],
                              axi.awaddr[AXI_AW-1:SRAM_AW], axi.araddr[AXI_AW-1:SRAM_AW]};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_wr)      state_d = (wr_oor || axi.wstrb == '0) ? WR_RESP : WR_BYTE;
        else if (grant_rd) state_d = rd_oor ? RD_RESP : RD_BYTE;
      end
      WR_BYTE: if (strb_q == '0) state_d = WR_RESP;
      WR_RESP: if (axi.bready) state_d = IDLE;
      RD_BYTE: if (lane_q == 2'd3) state_d = RD_RESP;
      RD_RESP: if (axi.rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: lane sequencing, SRAM port registers, response data.
  always_comb begin
    lane_d    = lane_q;
    strb_d    = strb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    last_wr_d = last_wr_q;
    csb_d     = csb_q;
    web_d     = web_q;
    addr0_d   = addr0_q;
    din0_d    = din0_q;
    first_wr  = first_lane(axi.wstrb);
    next_wr   = first_lane(strb_q);
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          last_wr_d = 1'b1;
          wdata_d   = axi.wdata;
          bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
          if (!wr_oor && axi.wstrb != '0) begin
            // strb_q tracks the lanes still to be written after the current one.
            lane_d  = first_wr;
            strb_d  = axi.wstrb & ~lane_bit(first_wr);
            csb_d   = 1'b0;
            web_d   = 1'b0;
            addr0_d = {axi.awaddr[SRAM_AW-1:2], first_wr};
            din0_d  = axi.wdata[{first_wr, 3'b000} +: 8];
          end
        end else if (grant_rd) begin
          last_wr_d = 1'b0;
          rdata_d   = '0;
          rresp_d   = rd_oor ? RESP_SLVERR : RESP_OKAY;
          if (!rd_oor) begin
            lane_d  = 2'd0;
            csb_d   = 1'b0;
            web_d   = 1'b1;
            addr0_d = {axi.araddr[SRAM_AW-1:2], 2'b00};
          end
        end
      end
      WR_BYTE: begin
        if (strb_q == '0) begin
          csb_d = 1'b1;
          web_d = 1'b1;
        end else begin
          lane_d  = next_wr;
          strb_d  = strb_q & ~lane_bit(next_wr);
          addr0_d = {addr0_q[SRAM_AW-1:2], next_wr};
          din0_d  = wdata_q[{next_wr, 3'b000} +: 8];
        end
      end
      RD_BYTE: begin
        // The macro returned this lane's byte during the cycle now closing.
        rdata_d[{lane_q, 3'b000} +: 8] = sram_dout0;
        if (lane_q == 2'd3) begin
          csb_d = 1'b1;
          web_d = 1'b1;
        end else begin
          lane_d  = lane_q + 2'd1;
          addr0_d = {addr0_q[SRAM_AW-1:2], lane_q + 2'd1};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; async reset drops the SRAM chip select at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q    <= 2'd0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      last_wr_q <= 1'b1;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      addr0_q   <= '0;
      din0_q    <= '0;
    end else begin
      lane_q    <= lane_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      last_wr_q <= last_wr_d;
      csb_q     <= csb_d;
      web_q     <= web_d;
      addr0_q   <= addr0_d;
      din0_q    <= din0_d;
    end
  end

  // Port outputs: readies pulse on the grant, valids follow the response states.
  always_comb begin
    axi.awready = grant_wr;
    axi.wready  = grant_wr;
    axi.arready = grant_rd;
    axi.bvalid  = (state_q == WR_RESP);
    axi.bresp   = bresp_q;
    axi.rvalid  = (state_q == RD_RESP);
    axi.rdata   = rdata_q;
    axi.rresp   = rresp_q;
    sram_csb0   = csb_q;
    sram_web0   = web_q;
    sram_addr0  = addr0_q;
    sram_din0   = din0_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_axi2sram_byte_bridge.sv
// Self-checking bench for axi2sram_byte_bridge: vector table, hand sequences
// (reset mid-write, arbitration, out-of-range address) and random traffic
// against a byte-array reference memory.
module tb_axi2sram_byte_bridge;
  import axi2sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic        sram_csb0, sram_web0;
  logic [12:0] sram_addr0;
  logic [7:0]  sram_din0;
  logic [7:0]  sram_dout0 = 8'h00;
  state_e      dbg_state;

  always #5 clock = ~clock;

  axi2sram_byte_bridge_if #(.AXI_AW(32)) axi ();

  axi2sram_byte_bridge #(.AXI_AW(32), .SRAM_AW(13)) dut (
    .clock      (clock),
    .reset      (reset),
    .axi        (axi.slave),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- SRAM macro model ----------------
  logic [7:0]  mem     [0:8191];
  logic [7:0]  ref_mem [0:8191];
  logic [7:0]  rd_byte;
  int          sram_cycles = 0;
  logic [20:0] wr_log[$];
  logic [31:0] exp_q[$];

  // Samples controls on the negedge; read data appears 3 time units later.
  always @(negedge clock) begin
    if (sram_csb0 === 1'b0) begin
      sram_cycles++;
      if (sram_web0 === 1'b0) begin
        mem[sram_addr0] = sram_din0;
        wr_log.push_back({sram_addr0, sram_din0});
      end else begin
        rd_byte = mem[sram_addr0];
        #3 sram_dout0 = rd_byte;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int base;
    base = int'(a[12:2]) * 4;
    for (int i = 0; i < 4; i++) if (s[i]) ref_mem[base + i] = d[i*8 +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int base;
    logic [31:0] r;
    base = int'(a[12:2]) * 4;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = ref_mem[base + i];
    return r;
  endfunction

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  // ---------------- drivers ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int n;
    resp = 2'bxx;
    lat  = -1;
    @(negedge clock);
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    #1;
    n = 0;
    while (!(axi.awready && axi.wready) && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 50) begin
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      timeout_fail("wr_grant");
      return;
    end
    @(negedge clock);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    lat = 1;
    #1;
    while (!axi.bvalid && lat < 50) begin
      @(negedge clock); #1; lat++;
    end
    if (!axi.bvalid) begin
      timeout_fail("wr_bvalid");
      return;
    end
    resp = axi.bresp;
    axi.bready = 1'b1;
    @(negedge clock);
    axi.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    data = 'x;
    resp = 2'bxx;
    lat  = -1;
    @(negedge clock);
    axi.araddr = a; axi.arvalid = 1'b1;
    #1;
    n = 0;
    while (!axi.arready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (n >= 50) begin
      axi.arvalid = 1'b0;
      timeout_fail("rd_grant");
      return;
    end
    @(negedge clock);
    axi.arvalid = 1'b0;
    lat = 1;
    #1;
    while (!axi.rvalid && lat < 50) begin
      @(negedge clock); #1; lat++;
    end
    if (!axi.rvalid) begin
      timeout_fail("rd_rvalid");
      return;
    end
    data = axi.rdata;
    resp = axi.rresp;
    axi.rready = 1'b1;
    @(negedge clock);
    axi.rready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          exp_lat;
    int          exp_cycles;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // Global time limit.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat, c0, k, n;
    logic [20:0] exp_e;
    bit          saw_b;
    int          grants[$];

    vecs[0] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, 5, 4, 32'h0, RESP_OKAY};
    vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 5, 4, 32'h1234_5678, RESP_OKAY};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'hAABB_CCDD, 4'h5, 3, 2, 32'h0, RESP_OKAY};
    vecs[3] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 5, 4, 32'h12BB_56DD, RESP_OKAY};
    vecs[4] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'h0, 1, 0, 32'h0, RESP_OKAY};
    vecs[5] = '{1'b0, 32'h0000_0102, 32'h0,         4'h0, 5, 4, 32'h12BB_56DD, RESP_OKAY};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0BAD_BEEF, 4'hF, 5, 4, 32'h0, RESP_OKAY};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 5, 4, 32'h0BAD_BEEF, RESP_OKAY};
    vecs[8] = '{1'b1, 32'h0000_1FFC, 32'hDEAD_C0DE, 4'hA, 3, 2, 32'h0, RESP_OKAY};
    vecs[9] = '{1'b0, 32'h0000_1FFD, 32'h0,         4'h0, 5, 4, 32'hDE00_C000, RESP_OKAY};

    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.bready = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;

    // ---- reset values ----
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #1;
    check("rst_awready", axi.awready, 0);
    check("rst_wready",  axi.wready, 0);
    check("rst_arready", axi.arready, 0);
    check("rst_bvalid",  axi.bvalid, 0);
    check("rst_rvalid",  axi.rvalid, 0);
    check("rst_bresp",   axi.bresp, RESP_OKAY);
    check("rst_rresp",   axi.rresp, RESP_OKAY);
    check("rst_rdata",   axi.rdata, 0);
    check("rst_csb0",    sram_csb0, 1);
    check("rst_web0",    sram_web0, 1);
    check("rst_addr0",   sram_addr0, 0);
    check("rst_din0",    sram_din0, 0);
    check("rst_state",   dbg_state, IDLE);

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      c0 = sram_cycles;
      wr_log.delete();
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        ref_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_blat", i), lat, vecs[i].exp_lat);
        check($sformatf("vec%0d_cycles", i), sram_cycles - c0, vecs[i].exp_cycles);
        k = 0;
        for (int ln = 0; ln < 4; ln++) begin
          if (vecs[i].strb[ln]) begin
            exp_e = {(vecs[i].addr[12:0] & 13'h1FFC) + 13'(ln), vecs[i].data[ln*8 +: 8]};
            if (k < wr_log.size()) check($sformatf("vec%0d_wlog%0d", i, k), wr_log[k], exp_e);
            else check($sformatf("vec%0d_wlog%0d_missing", i, k), 0, exp_e);
            k++;
          end
        end
      end else begin
        do_read(vecs[i].addr, rd, resp, lat);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_rlat", i), lat, vecs[i].exp_lat);
        check($sformatf("vec%0d_cycles", i), sram_cycles - c0, vecs[i].exp_cycles);
      end
    end

    // ---- reset during the third byte of a full-word write ----
    do_write(32'h200, 32'h1122_3344, 4'hF, resp, lat);
    ref_write(32'h200, 32'h1122_3344, 4'hF);
    @(negedge clock);
    axi.awaddr = 32'h200; axi.wdata = 32'hA5B6_C7D8; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    #1;
    check("rstseq_grant", axi.awready && axi.wready, 1);
    @(negedge clock);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("rstseq_csb0_async", sram_csb0, 1);
    check("rstseq_state", dbg_state, IDLE);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    saw_b = 1'b0;
    repeat (8) begin
      @(negedge clock); #1;
      if (axi.bvalid) saw_b = 1'b1;
    end
    check("rstseq_no_bvalid", saw_b, 0);
    ref_write(32'h200, 32'hA5B6_C7D8, 4'b0011);

    // ---- arbitration after reset: read, write, read ----
    @(negedge clock);
    axi.araddr = 32'h300; axi.arvalid = 1'b1;
    axi.awaddr = 32'h304; axi.wdata = 32'hCAFE_F00D; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.bready = 1'b1; axi.rready = 1'b1;
    n = 0;
    while (grants.size() < 3 && n < 60) begin
      #1;
      if (axi.arvalid && axi.arready) grants.push_back(0);
      if (axi.awready && axi.wready) grants.push_back(1);
      if (grants.size() < 3) begin
        @(negedge clock);
        n++;
      end
    end
    @(negedge clock);
    axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    repeat (10) @(negedge clock);
    axi.bready = 1'b0; axi.rready = 1'b0;
    if (grants.size() < 3) timeout_fail("arb_grants");
    else begin
      check("arb_grant0_read",  grants[0], 0);
      check("arb_grant1_write", grants[1], 1);
      check("arb_grant2_read",  grants[2], 0);
    end
    ref_write(32'h304, 32'hCAFE_F00D, 4'hF);

    do_read(32'h200, rd, resp, lat);
    check("rstseq_readback", rd, 32'h1122_C7D8);
    do_read(32'h304, rd, resp, lat);
    check("arb_write_readback", rd, 32'hCAFE_F00D);

    // ---- address above the SRAM ----
    c0 = sram_cycles;
    do_read(32'h2000, rd, resp, lat);
`ifdef AXI2SRAM_RANGE_CHECK_EN
    check("oor_rd_resp", resp, RESP_SLVERR);
    check("oor_rd_data", rd, 0);
    check("oor_rd_lat", lat, 1);
    check("oor_rd_cycles", sram_cycles - c0, 0);
    c0 = sram_cycles;
    do_write(32'h4000_0000, 32'h5555_AAAA, 4'hF, resp, lat);
    check("oor_wr_resp", resp, RESP_SLVERR);
    check("oor_wr_lat", lat, 1);
    check("oor_wr_cycles", sram_cycles - c0, 0);
`else
    check("alias_rd_resp", resp, RESP_OKAY);
    check("alias_rd_data", rd, 32'h0BAD_BEEF);
    check("alias_rd_lat", lat, 5);
    check("alias_rd_cycles", sram_cycles - c0, 4);
`endif

    // ---- random traffic against the reference memory ----
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = 32'h400 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      c0 = sram_cycles;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, resp, lat);
        ref_write(a, d, s);
        check($sformatf("rnd%0d_bresp", t), resp, RESP_OKAY);
        check($sformatf("rnd%0d_blat", t), lat, $countones(s) + 1);
        check($sformatf("rnd%0d_wcycles", t), sram_cycles - c0, $countones(s));
      end else begin
        exp_q.push_back(ref_read(a));
        do_read(a, rd, resp, lat);
        check($sformatf("rnd%0d_rdata", t), rd, exp_q.pop_front());
        check($sformatf("rnd%0d_rresp", t), resp, RESP_OKAY);
        check($sformatf("rnd%0d_rlat", t), lat, 5);
      end
    end

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
